f_accumulator: RTL and testbench

Single-precision (IEEE-754 binary32) accumulator that sits directly downstream of `f_multiplier` and sums its product stream into one result. Together they form a floating-point MAC / dot-product path. Each packet of terms is delimited by `in_last`. At the end of a packet the block emits the rounded sum and the term count, then clears itself for the next packet. Internally it is a fixed-latency multi-cycle adder FSM: align, add, normalize/round.

---
 rtl/fp_pkg.sv | 19 +
 rtl/f_accumulator_if.sv | 25 ++
 rtl/fp_lzc.sv | 15 +
 rtl/f_accumulator.sv | 194 +++++++++++++++++++
 tb/tb_f_accumulator.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared binary32 field widths, special encodings and the accumulator FSM state type.
package fp_pkg;

  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int EXP_BIAS = 127;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    DONE
  } state_t;

endpackage

// File: rtl/f_accumulator_if.sv
// Term input stream and packet-result output of the floating-point accumulator.
interface f_accumulator_if #(
  parameter int BIT_WIDTH = 32,
  parameter int CNT_WIDTH = 16
);

  logic                 in_valid;
  logic                 in_ready;
  logic [BIT_WIDTH-1:0] in_data;
  logic                 in_last;
  logic                 out_valid;
  logic [BIT_WIDTH-1:0] out_data;
  logic [CNT_WIDTH-1:0] out_count;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, out_valid, out_data, out_count
  );

endinterface

// File: rtl/fp_lzc.sv
// Leading-zero counter for the 28-bit adder result; an all-zero input reports 28.
module fp_lzc (
  input  logic [27:0] a,
  output logic [4:0]  lz
);

  // Ascending scan so the most significant set bit has the final say.
  always_comb begin
    lz = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (a[i]) lz = 5'(27 - i);
    end
  end

endmodule

// File: rtl/f_accumulator.sv
// Binary32 packet accumulator: one term per pass through a four-state align/add/normalize FSM,
// rounded sum and term count emitted on the last term of each packet.
module f_accumulator
  import fp_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input logic clk,
  input logic rstn,
  f_accumulator_if.slave bus
);

  state_t state, state_next;

  logic [BIT_WIDTH-1:0] acc, term_r;
  logic                 last_r;
  logic [CNT_WIDTH-1:0] count;

  logic                 spec_r;
  logic [BIT_WIDTH-1:0] spec_val_r;
  logic                 sign_r;
  logic                 sub_r;
  logic [EXP_W-1:0]     exp_r;
  logic [26:0]          x_r, y_r;
  logic [27:0]          sum_r;

  logic                 out_valid_r;
  logic [BIT_WIDTH-1:0] out_data_r;
  logic [CNT_WIDTH-1:0] out_count_r;

  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb, e_big, e_small, e_diff;
  logic [MAN_W-1:0] ma, mb, m_big, m_small;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_big;
  logic [26:0]      sig_small, lost_mask, small_sh, al_x;
  logic             al_sign, al_special;
  logic [31:0]      al_special_val;

  logic [4:0]        lz;
  logic [26:0]       nm;
  logic signed [9:0] ne, nef;
  logic              rnd_up;
  logic [24:0]       rnd_sig;
  logic [22:0]       nman;
  logic [31:0]       norm_res;

  assign bus.in_ready  = (state == IDLE) && rstn;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_count = out_count_r;

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid && bus.in_ready) state_next = ALIGN;
      ALIGN:   state_next = ADD;
      ADD:     state_next = NORM;
      NORM:    state_next = last_r ? DONE : IDLE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand unpack, special-value bypass and alignment of the smaller magnitude.
  always_comb begin
    sa     = acc[31];
    ea     = acc[30:23];
    ma     = acc[22:0];
    sb     = term_r[31];
    eb     = term_r[30:23];
    mb     = term_r[22:0];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == '1) && (ma == '0);
    b_inf  = (eb == '1) && (mb == '0);
    a_nan  = (ea == '1) && (ma != '0);
    b_nan  = (eb == '1) && (mb != '0);
    a_big  = {ea, ma} >= {eb, mb};

    e_big     = a_big ? ea : eb;
    e_small   = a_big ? eb : ea;
    m_big     = a_big ? ma : mb;
    m_small   = a_big ? mb : ma;
    al_sign   = a_big ? sa : sb;
    e_diff    = e_big - e_small;
    sig_small = {1'b1, m_small, 3'b000};
    lost_mask = ~(27'h7FFFFFF << e_diff);
    al_x      = {1'b1, m_big, 3'b000};

    if (e_diff >= 8'd27) small_sh = 27'd1;
    else small_sh = (sig_small >> e_diff) | {26'd0, |(sig_small & lost_mask)};

    al_special     = 1'b1;
    al_special_val = acc;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) al_special_val = QNAN;
    else if (a_inf)  al_special_val = acc;
    else if (b_inf)  al_special_val = term_r;
    else if (b_zero) al_special_val = acc;
    else if (a_zero) al_special_val = term_r;
    else             al_special     = 1'b0;
  end

  fp_lzc u_lzc (
    .a  (sum_r),
    .lz (lz)
  );

  // Bring the leading one to bit 26, keeping guard/round/sticky below the 24-bit significand.
  always_comb begin
    if (lz == 5'd0) nm = {sum_r[27:2], sum_r[1] | sum_r[0]};
    else            nm = sum_r[26:0] << (lz - 5'd1);
    ne      = $signed({2'b00, exp_r}) - $signed({5'b00000, lz}) + 10'sd1;
    rnd_up  = nm[2] & (nm[1] | nm[0] | nm[3]);
    rnd_sig = {1'b0, nm[26:3]} + {24'd0, rnd_up};

    if (rnd_sig[24]) begin
      nman = rnd_sig[23:1];
      nef  = ne + 10'sd1;
    end else begin
      nman = rnd_sig[22:0];
      nef  = ne;
    end

    if (spec_r)                norm_res = spec_val_r;
    else if (sum_r == '0)      norm_res = '0;
    else if (nef >= 10'sd255)  norm_res = {sign_r, POS_INF[30:0]};
    else if (nef <= 10'sd0)    norm_res = {sign_r, 31'd0};
    else                       norm_res = {sign_r, nef[7:0], nman};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc         <= '0;
      term_r      <= '0;
      last_r      <= 1'b0;
      count       <= '0;
      spec_r      <= 1'b0;
      spec_val_r  <= '0;
      sign_r      <= 1'b0;
      sub_r       <= 1'b0;
      exp_r       <= '0;
      x_r         <= '0;
      y_r         <= '0;
      sum_r       <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_count_r <= '0;
    end else begin
      out_valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            term_r <= bus.in_data;
            last_r <= bus.in_last;
            if (count != '1) count <= count + 1'b1;
          end
        end
        ALIGN: begin
          spec_r     <= al_special;
          spec_val_r <= al_special_val;
          sign_r     <= al_sign;
          sub_r      <= sa ^ sb;
          exp_r      <= e_big;
          x_r        <= al_x;
          y_r        <= small_sh;
        end
        ADD: begin
          if (sub_r) sum_r <= {1'b0, x_r} - {1'b0, y_r};
          else       sum_r <= {1'b0, x_r} + {1'b0, y_r};
        end
        NORM: begin
          acc <= norm_res;
          if (last_r) begin
            out_valid_r <= 1'b1;
            out_data_r  <= norm_res;
            out_count_r <= count;
          end
        end
        DONE: begin
          acc   <= '0;
          count <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_f_accumulator.sv
// Directed bench for f_accumulator: an exact-arithmetic binary32 model predicts every output cycle,
// and hand-computed packet results pin both the model and the design.
module tb_f_accumulator;
  import fp_pkg::*;

  logic clk;
  logic rstn;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 0;

  int          busy      = 0;
  bit          last_m    = 0;
  logic [31:0] acc_m     = '0;
  logic [15:0] cnt_m     = '0;
  bit          exp_valid = 0;
  logic [31:0] exp_data  = '0;
  logic [15:0] exp_count = '0;

  int          seen_pulses = 0;
  logic [31:0] seen_data   = '0;
  logic [15:0] seen_count  = '0;

  f_accumulator_if #(.BIT_WIDTH(32), .CNT_WIDTH(16)) bus ();

  f_accumulator #(.BIT_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Binary32 addition done exactly on a 2^-149 integer grid, then rounded to nearest-even.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [299:0] va, vb, mag, rem, half;
    logic [24:0]  kept;
    logic         s, up;
    int           p, sh, e;
    if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0)) return QNAN;
    if (a[30:23] == 8'hFF && b[30:23] == 8'hFF) return (a[31] == b[31]) ? a : QNAN;
    if (a[30:23] == 8'hFF) return a;
    if (b[30:23] == 8'hFF) return b;
    if (b[30:23] == 8'h00) return a;
    if (a[30:23] == 8'h00) return b;
    va = {276'd0, 1'b1, a[22:0]} << (int'(a[30:23]) - 1);
    vb = {276'd0, 1'b1, b[22:0]} << (int'(b[30:23]) - 1);
    if (a[31] == b[31]) begin
      mag = va + vb;
      s   = a[31];
    end else if (va > vb) begin
      mag = va - vb;
      s   = a[31];
    end else if (vb > va) begin
      mag = vb - va;
      s   = b[31];
    end else begin
      return 32'h00000000;
    end
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    if (p < 23) return {s, 31'd0};
    sh   = p - 23;
    kept = 25'(mag >> sh);
    rem  = mag & ((300'd1 << sh) - 300'd1);
    half = (sh > 0) ? (300'd1 << (sh - 1)) : 300'd0;
    up   = (sh > 0) && ((rem > half) || ((rem == half) && kept[0]));
    kept = kept + {24'd0, up};
    e    = p - 22;
    if (kept[24]) begin
      kept = kept >> 1;
      e    = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    return {s, 8'(e), kept[22:0]};
  endfunction

  // Cycle-level expectation: who is busy, when the result pulse is due, what it must carry.
  always @(posedge clk) begin
    if (!rstn) begin
      busy      = 0;
      last_m    = 0;
      acc_m     = '0;
      cnt_m     = '0;
      exp_valid = 0;
      exp_data  = '0;
      exp_count = '0;
    end else begin
      exp_valid = 0;
      if (busy > 0) begin
        busy = busy - 1;
        if (last_m && busy == 1) begin
          exp_valid = 1;
          exp_data  = acc_m;
          exp_count = cnt_m;
          acc_m     = '0;
          cnt_m     = '0;
        end
      end else if (bus.in_valid) begin
        acc_m  = fp_add(acc_m, bus.in_data);
        if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
        last_m = bus.in_last;
        busy   = bus.in_last ? 4 : 3;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic compareLoop();
    forever begin
      @(negedge clk);
      if (chk_en) begin
        checkOutput("cyc_in_ready",  {31'd0, bus.in_ready},  {31'd0, (rstn === 1'b1) && (busy == 0)});
        checkOutput("cyc_out_valid", {31'd0, bus.out_valid}, {31'd0, exp_valid});
        checkOutput("cyc_out_data",  bus.out_data,           exp_data);
        checkOutput("cyc_out_count", {16'd0, bus.out_count}, {16'd0, exp_count});
        if (bus.out_valid === 1'b1) begin
          seen_pulses++;
          seen_data  = bus.out_data;
          seen_count = bus.out_count;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic [31:0] d, input logic l, input bit hold);
    bit ok;
    ok           = 0;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) ok = 1;
    end
    @(posedge clk);
    #1;
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout term %h got no in_ready expected in_ready within 20 cycles", d);
    end
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic waitPulse(input int p0, input string name);
    bit got;
    got = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(posedge clk);
      if (seen_pulses != p0) got = 1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_pulse_timeout got no out_valid expected one within 12 cycles", name);
    end
  endtask

  task automatic runPacket(input string name, input int n, input logic [31:0] t0, input logic [31:0] t1,
                           input logic [31:0] xd, input logic [15:0] xc);
    int p0;
    p0 = seen_pulses;
    if (n == 2) applyStimulus(t0, 1'b0, 1'b0);
    applyStimulus((n == 2) ? t1 : t0, 1'b1, 1'b0);
    waitPulse(p0, name);
    checkOutput({name, "_data"},  seen_data, xd);
    checkOutput({name, "_count"}, {16'd0, seen_count}, {16'd0, xc});
  endtask

  initial begin
    int p0;
    rstn         = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    fork
      compareLoop();
    join_none

    checkOutput("model_sum",     fp_add(32'h3F800000, 32'h40000000), 32'h40400000);
    checkOutput("model_tie",     fp_add(32'h3F800000, 32'h33800000), 32'h3F800000);
    checkOutput("model_roundup", fp_add(32'h3F800000, 32'h34400000), 32'h3F800002);
    checkOutput("model_infinf",  fp_add(32'h7F800000, 32'hFF800000), 32'h7FC00000);
    checkOutput("model_ovf",     fp_add(32'h7F7FFFFF, 32'h7F7FFFFF), 32'h7F800000);
    checkOutput("model_cancel",  fp_add(32'h3F800000, 32'hBF800000), 32'h00000000);

    repeat (3) @(posedge clk);
    #1;
    chk_en = 1;
    checkOutput("reset_in_ready",  {31'd0, bus.in_ready},  32'd0);
    checkOutput("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("reset_out_data",  bus.out_data,           32'd0);
    checkOutput("reset_out_count", {16'd0, bus.out_count}, 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    runPacket("one_plus_two", 2, 32'h3F800000, 32'h40000000, 32'h40400000, 16'd2);
    runPacket("cancel",       2, 32'h3F800000, 32'hBF800000, 32'h00000000, 16'd2);
    runPacket("single",       1, 32'h40400000, 32'h00000000, 32'h40400000, 16'd1);
    runPacket("tie_even",     2, 32'h3F800000, 32'h33800000, 32'h3F800000, 16'd2);
    runPacket("round_up",     2, 32'h3F800000, 32'h34400000, 32'h3F800002, 16'd2);
    runPacket("inf_minus",    2, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 16'd2);
    runPacket("overflow",     2, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 16'd2);
    runPacket("nan_sticky",   2, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 16'd2);
    runPacket("denormal",     2, 32'h00000001, 32'h3F800000, 32'h3F800000, 16'd2);

    p0 = seen_pulses;
    for (int i = 0; i < 10; i++) applyStimulus(32'h3F800000, i == 9, i != 9);
    waitPulse(p0, "burst");
    checkOutput("burst_data",  seen_data, 32'h41200000);
    checkOutput("burst_count", {16'd0, seen_count}, 32'd10);

    p0 = seen_pulses;
    applyStimulus(32'h3F800000, 1'b0, 1'b0);
    applyStimulus(32'h40000000, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("rst_no_pulse",  32'(seen_pulses),       32'(p0));
    checkOutput("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("rst_out_data",  bus.out_data,           32'd0);
    checkOutput("rst_out_count", {16'd0, bus.out_count}, 32'd0);
    runPacket("after_reset", 1, 32'h40000000, 32'h00000000, 32'h40000000, 16'd1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
